// File: rtl/mac_pkg.sv
// Shared definitions for the offset multiply-add pipeline and its consumers.
package mac_pkg;

    // Accept edge to out_valid, counted in rising edges with no stall.
    localparam int MAC_LAT = 4;

    // Offset added to every product-sum unless a different one is configured.
    localparam logic [15:0] DEFAULT_OFFSET = 16'h004E;

    // Result width of the default configuration.
    localparam int MAC_RES_W = 16;

    // One result beat as seen by a downstream consumer.
    typedef struct packed {
        logic [MAC_RES_W-1:0] g;
        logic                 ovf;
        logic                 acc_flag;
    } mac_result_t;

endpackage

// File: rtl/mac_offset_pipe_sat_add.sv
// (OUT_W+1)-bit unsigned add. The carry into bit OUT_W is reported as ovf.
// The result either wraps to OUT_W bits or clamps to all-ones.
module sat_add #(
    parameter int OUT_W  = 16,
    parameter int SAT_EN = 0
) (
    input  logic [OUT_W:0]   x,
    input  logic [OUT_W:0]   y,
    output logic [OUT_W-1:0] sum,
    output logic             ovf
);

    logic [OUT_W:0] r;

    // Wide sum; any overflow beyond OUT_W bits is flagged and then wrapped or clamped.
    always_comb begin
        r   = x + y;
        ovf = r[OUT_W];
        if ((SAT_EN != 0) && r[OUT_W]) begin
            sum = '1;
        end else begin
            sum = r[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/mac_offset_pipe.sv
// Four-stage pipelined g = a*b + c + OFFSET with an optional running accumulate.
//
// Handshake: a beat transfers on the input when in_valid && in_ready, and on the
// output when out_valid && out_ready. Every stage moves together when
// adv = !out_valid || out_ready and holds otherwise. in_ready is adv.
module mac_offset_pipe
    import mac_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               OUT_W  = 16,
    parameter logic [OUT_W-1:0] OFFSET = OUT_W'(DEFAULT_OFFSET),
    parameter int               SAT_EN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_acc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  g,
    output logic              out_ovf
);

    localparam int PW  = 2 * DATA_W;
    localparam int OW1 = OUT_W + 1;

    logic adv;

    // S1: product, c and the accumulate flag travel together.
    logic              v1;
    logic [PW-1:0]     p1;
    logic [DATA_W-1:0] c1;
    logic              acc1;

    // S2: product plus c.
    logic              v2;
    logic [OW1-1:0]    s2;
    logic              acc2;

    // S3: plus the constant offset.
    logic              v3;
    logic [OW1-1:0]    t3;
    logic              acc3;

    // S4: output register and the running accumulator.
    logic              v4;
    logic [OUT_W-1:0]  g4;
    logic              ovf4;
    logic [OUT_W-1:0]  acc_q;

    logic [OW1-1:0]    add_x;
    logic [OUT_W-1:0]  sum4;
    logic              ovf_d;

    assign adv       = !v4 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v4;
    assign g         = g4;
    assign out_ovf   = ovf4;

    // An in_acc=0 beat ignores the accumulator, which restarts the chain.
    always_comb begin
        add_x = '0;
        if (acc3) begin
            add_x = {1'b0, acc_q};
        end
    end

    sat_add #(
        .OUT_W  (OUT_W),
        .SAT_EN (SAT_EN)
    ) u_sat_add (
        .x   (add_x),
        .y   (t3),
        .sum (sum4),
        .ovf (ovf_d)
    );

    // Stage registers: all shift on adv, bubbles included; reset clears every valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1    <= 1'b0;
            p1    <= '0;
            c1    <= '0;
            acc1  <= 1'b0;
            v2    <= 1'b0;
            s2    <= '0;
            acc2  <= 1'b0;
            v3    <= 1'b0;
            t3    <= '0;
            acc3  <= 1'b0;
            v4    <= 1'b0;
            g4    <= '0;
            ovf4  <= 1'b0;
            acc_q <= '0;
        end else if (adv) begin
            v1   <= in_valid;
            p1   <= PW'(a) * PW'(b);
            c1   <= c;
            acc1 <= in_acc;

            v2   <= v1;
            s2   <= OW1'(p1) + OW1'(c1);
            acc2 <= acc1;

            v3   <= v2;
            t3   <= s2 + OW1'(OFFSET);
            acc3 <= acc2;

            v4   <= v3;
            // Output and accumulator only change when a real beat enters S4.
            if (v3) begin
                g4    <= sum4;
                ovf4  <= ovf_d;
                acc_q <= sum4;
            end
        end
    end

endmodule

// File: tb/tb_mac_offset_pipe.sv
// Directed bench for mac_offset_pipe: a wrapping and a saturating instance share
// one stimulus stream; a 12/26-bit instance covers the wide configuration.
module tb_mac_offset_pipe;
    import mac_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_acc;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] g;
    logic        out_ovf;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_g;
    logic        s_out_ovf;

    logic        w_in_valid;
    logic [11:0] w_a;
    logic [11:0] w_b;
    logic [11:0] w_c;
    logic        w_out_ready;
    logic        w_in_ready;
    logic        w_out_valid;
    logic [25:0] w_g;
    logic        w_out_ovf;

    // Expected {ovf, g} per accepted beat, one queue per shared-stimulus instance.
    logic [16:0] exp_q[$];
    logic [16:0] sat_q[$];

    int n_cmp = 0;
    int n_mis = 0;

    logic        prev_stall;
    logic [15:0] prev_g;

    mac_offset_pipe #(.DATA_W(8), .OUT_W(16), .OFFSET(16'h004E), .SAT_EN(0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_acc(in_acc), .a(a), .b(b), .c(c), .out_valid(out_valid),
        .out_ready(out_ready), .g(g), .out_ovf(out_ovf)
    );

    mac_offset_pipe #(.DATA_W(8), .OUT_W(16), .OFFSET(16'h004E), .SAT_EN(1)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_acc(in_acc), .a(a), .b(b), .c(c), .out_valid(s_out_valid),
        .out_ready(out_ready), .g(s_g), .out_ovf(s_out_ovf)
    );

    mac_offset_pipe #(.DATA_W(12), .OUT_W(26), .OFFSET(26'h0), .SAT_EN(0)) u_wide (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_acc(1'b0), .a(w_a), .b(w_b), .c(w_c), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .g(w_g), .out_ovf(w_out_ovf)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: present one beat, hold it until accepted, record expectations.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tc,
                        input logic tacc, input logic [15:0] eg, input logic eovf,
                        input logic [15:0] esg);
        int cnt;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        c = tc;
        in_acc = tacc;
        @(negedge clk);
        cnt = 0;
        while (!in_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back({eovf, eg});
            sat_q.push_back({eovf, esg});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until every expected result has been consumed.
    task automatic drain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || sat_q.size() != 0) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("drain_empty", 32'(exp_q.size() + sat_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pop on every output transfer; check stall stability.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("main_unexpected_out", 32'd1, 32'd0);
                end else begin
                    check("main_result", 32'({out_ovf, g}), 32'(exp_q.pop_front()));
                end
            end
            if (s_out_valid && out_ready) begin
                if (sat_q.size() == 0) begin
                    check("sat_unexpected_out", 32'd1, 32'd0);
                end else begin
                    check("sat_result", 32'({s_out_ovf, s_g}), 32'(sat_q.pop_front()));
                end
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (prev_stall) begin
                    check("stall_g_held", 32'(g), 32'(prev_g));
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_g     <= g;
        end
    end

    initial begin
        int edges;
        int k;
        reset = 1'b1;
        in_valid = 1'b0;
        in_acc = 1'b0;
        a = '0;
        b = '0;
        c = '0;
        out_ready = 1'b1;
        w_in_valid = 1'b0;
        w_a = '0;
        w_b = '0;
        w_c = '0;
        w_out_ready = 1'b1;
        prev_stall = 1'b0;
        prev_g = '0;

        // Reset state, with inputs active to show they are ignored.
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 8'd9;
        b = 8'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_g", 32'(g), 32'd0);
        check("reset_ovf", 32'(out_ovf), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", 32'(out_valid), 32'd0);

        // Single beat and its latency.
        send(8'd3, 8'd4, 8'd5, 1'b0, 16'h005F, 1'b0, 16'h005F);
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", 32'(edges), 32'(MAC_LAT));
        drain();

        // Max operands, then accumulate into wrap/clamp.
        send(8'hFF, 8'hFF, 8'hFF, 1'b0, 16'hFF4E, 1'b0, 16'hFF4E);
        send(8'hFF, 8'hFF, 8'hFF, 1'b1, 16'hFE9C, 1'b1, 16'hFFFF);
        // Chain restart, then a small accumulate: 0x4F + (6+1+0x4E) = 0xA4.
        send(8'd1, 8'd1, 8'd0, 1'b0, 16'h004F, 1'b0, 16'h004F);
        send(8'd2, 8'd3, 8'd1, 1'b1, 16'h00A4, 1'b0, 16'h00A4);
        drain();

        // Back-to-back stream with no output bubbles.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(8'(i), 8'(i), 8'd0, 1'b0, 16'(i * i + 16'h4E), 1'b0,
                         16'(i * i + 16'h4E));
                end
            end
            begin
                k = 0;
                while (!out_valid && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                for (int j = 0; j < 8; j++) begin
                    check("no_bubble", 32'(out_valid), 32'd1);
                    @(negedge clk);
                end
            end
        join
        drain();

        // Same stream with the consumer stalling for three cycles.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(8'(i), 8'(i), 8'd0, 1'b0, 16'(i * i + 16'h4E), 1'b0,
                         16'(i * i + 16'h4E));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight, then accumulate from a cleared accumulator.
        send(8'd7, 8'd7, 8'd7, 1'b1, 16'h0000, 1'b0, 16'h0000);
        send(8'd8, 8'd8, 8'd8, 1'b1, 16'h0000, 1'b0, 16'h0000);
        send(8'd9, 8'd9, 8'd9, 1'b1, 16'h0000, 1'b0, 16'h0000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        sat_q.delete();
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_g", 32'(g), 32'd0);
        check("midreset_sat_valid", 32'(s_out_valid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("midreset_no_leak", 32'(out_valid), 32'd0);
        send(8'd1, 8'd1, 8'd0, 1'b1, 16'h004F, 1'b0, 16'h004F);
        drain();

        // Wide configuration: 0xFFF*0xFFF + 0xFFF, no offset.
        w_a = 12'hFFF;
        w_b = 12'hFFF;
        w_c = 12'hFFF;
        w_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        k = 0;
        while (!w_out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("wide_valid", 32'(w_out_valid), 32'd1);
        check("wide_g", 32'(w_g), 32'h0FFF000);
        check("wide_ovf", 32'(w_out_ovf), 32'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
